// File: rtl/cdc_xfer_pkg.sv
// Shared definitions for the clkA-side transfer scheduler: FSM state
// encoding, default parameter values and a counter-width helper.
package cdc_xfer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_WAIT  = ST_WAIT,
    S_GAP   = ST_GAP,
    S_ERROR = ST_ERROR
  } state_e;

  localparam int DEF_N           = 8;
  localparam int DEF_NREQ        = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 255;
  localparam int DEF_TW          = 8;
  localparam int DEF_GAP_CYCLES  = 2;

  // Number of bits needed to hold values 0..maxval, never less than one.
  function automatic int cnt_width(input int maxval);
    int w;
    w = 1;
    while ((1 << w) <= maxval) w++;
    return w;
  endfunction

endpackage

// File: rtl/cdc_xfer_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational pick of the first active request at or
// above the pointer (with wrap), plus a pointer that moves past the winner.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                     clkA,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NREQ-1:0]          req,
  output logic [$clog2(NREQ)-1:0]  sel,
  output logic                     any
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] idx;
  int            pos;

  // Search upward from the pointer, wrapping at NREQ, and keep the first hit.
  always_comb begin
    any = 1'b0;
    sel = '0;
    idx = '0;
    pos = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(ptr_q) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = IW'(pos);
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

  // When a grant is taken, the winner becomes lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (en && any) begin
      ptr_d = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cdc_xfer_scheduler.sv
// Source-side scheduler sharing one toggle-strobe synchronizer channel
// between several requesters: arbitrate, launch, wait for the toggle ack,
// hold off, and park in a sticky error state if the ack never comes.
module cdc_xfer_scheduler import cdc_xfer_pkg::*; #(
  parameter int N           = DEF_N,
  parameter int NREQ        = DEF_NREQ,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int TW          = DEF_TW,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                     clkA,
  input  logic                     rst_n,
  input  logic                     enaA,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*N-1:0]        req_data,
  output logic [NREQ-1:0]          grant,
  output logic [N-1:0]             xfer_data,
  output logic                     xfer_stb,
  input  logic                     ack_tgl,
  output logic [$clog2(NREQ)-1:0]  src_id,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic                     err,
  input  logic                     err_clr
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = cnt_width(GAP_CYCLES);

  state_e                 state_q, state_d;
  logic [N-1:0]           xfer_data_q, xfer_data_d;
  logic                   xfer_stb_q, xfer_stb_d;
  logic [IW-1:0]          src_id_q, src_id_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic                   done_q, done_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [GW-1:0]          gcnt_q, gcnt_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;

  logic                   ack_s;
  logic                   ack_match;
  logic                   arb_en;
  logic                   arb_any;
  logic [IW-1:0]          arb_sel;
  logic [N-1:0]           data_sel;

  assign ack_s     = ack_sync_q[SYNC_STAGES-1];
  assign ack_match = (ack_s == xfer_stb_q);
  assign arb_en    = enaA && (state_q == S_IDLE);

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clkA  (clkA),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (req),
    .sel   (arb_sel),
    .any   (arb_any)
  );

  // Shift the asynchronous ack toggle in; this chain ignores enaA.
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_tgl};
  end

  // Select the winning requester's data word.
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_sel == IW'(i)) data_sel = req_data[i*N +: N];
    end
  end

  // Next-state and output decode; pulses default low so they last one cycle.
  always_comb begin
    state_d       = state_q;
    xfer_data_d   = xfer_data_q;
    xfer_stb_d    = xfer_stb_q;
    src_id_d      = src_id_q;
    grant_d       = '0;
    done_d        = 1'b0;
    timeout_err_d = 1'b0;
    tcnt_d        = tcnt_q;
    gcnt_d        = gcnt_q;
    if (enaA) begin
      case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            xfer_data_d      = data_sel;
            xfer_stb_d       = ~xfer_stb_q;
            src_id_d         = arb_sel;
            grant_d[arb_sel] = 1'b1;
            tcnt_d           = '0;
            state_d          = S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack_match) begin
            done_d  = 1'b1;
            gcnt_d  = '0;
            state_d = S_GAP;
          end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            timeout_err_d = 1'b1;
            state_d       = S_ERROR;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        S_GAP: begin
          if (gcnt_q == GW'(GAP_CYCLES)) state_d = S_IDLE;
          else                           gcnt_d  = gcnt_q + GW'(1);
        end
        S_ERROR: begin
          if (err_clr && ack_match) begin
            gcnt_d  = '0;
            state_d = S_GAP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      xfer_data_q   <= '0;
      xfer_stb_q    <= 1'b0;
      src_id_q      <= '0;
      grant_q       <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      tcnt_q        <= '0;
      gcnt_q        <= '0;
      ack_sync_q    <= '0;
    end else begin
      state_q       <= state_d;
      xfer_data_q   <= xfer_data_d;
      xfer_stb_q    <= xfer_stb_d;
      src_id_q      <= src_id_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      tcnt_q        <= tcnt_d;
      gcnt_q        <= gcnt_d;
      ack_sync_q    <= ack_sync_d;
    end
  end

  assign grant       = grant_q;
  assign xfer_data   = xfer_data_q;
  assign xfer_stb    = xfer_stb_q;
  assign src_id      = src_id_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE);
  assign err         = (state_q == S_ERROR);

endmodule

// File: tb/tb_cdc_xfer_scheduler.sv
// Scoreboard bench for cdc_xfer_scheduler: the stimulus pushes the expected
// grant/done/timeout events, a monitor pops and compares them as they appear.
module tb_cdc_xfer_scheduler;

  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 255;
  localparam int TW      = 8;
  localparam int GAP     = 2;
  localparam int IW      = 2;

  localparam int EV_GRANT   = 0;
  localparam int EV_DONE    = 1;
  localparam int EV_TIMEOUT = 2;

  typedef struct {
    int              kind;
    logic [NREQ-1:0] grant;
    logic [N-1:0]    data;
    logic [IW-1:0]   src;
    logic            stb;
    int              lat;
  } expT;

  logic              clkA;
  logic              rst_n;
  logic              enaA;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic [N-1:0]      xfer_data;
  logic              xfer_stb;
  logic              ack_tgl;
  logic [IW-1:0]     src_id;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic              err;
  logic              err_clr;

  expT  expQ[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cycleCnt = 0;
  int   lastGrantCycle = 0;
  int   grantsSeen = 0;
  logic expStb = 1'b0;

  bit   ackAuto = 1'b0;
  bit   ackNow = 1'b0;
  int   ackDelay = 4;
  logic seenStb;
  int   ackLeft;

  cdc_xfer_scheduler #(
    .N (N), .NREQ (NREQ), .SYNC_STAGES (SYNC),
    .TIMEOUT (TIMEOUT), .TW (TW), .GAP_CYCLES (GAP)
  ) dut (
    .clkA        (clkA),
    .rst_n       (rst_n),
    .enaA        (enaA),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .xfer_data   (xfer_data),
    .xfer_stb    (xfer_stb),
    .ack_tgl     (ack_tgl),
    .src_id      (src_id),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .err         (err),
    .err_clr     (err_clr)
  );

  // Free-running source clock, 10 time units per cycle.
  initial clkA = 1'b0;
  always #5 clkA = ~clkA;

  // Cycle counter used to measure event latencies.
  always @(posedge clkA) cycleCnt <= cycleCnt + 1;

  // Destination model: returns the strobe level ackDelay edges after the
  // strobe changes (detected one edge late), or on demand via ackNow.
  always @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      ack_tgl <= 1'b0;
      seenStb <= 1'b0;
      ackLeft <= 0;
    end else begin
      if (xfer_stb != seenStb) begin
        seenStb <= xfer_stb;
        if (ackAuto) ackLeft <= ackDelay - 1;
      end else if (ackLeft > 0) begin
        ackLeft <= ackLeft - 1;
        if (ackLeft == 1) ack_tgl <= xfer_stb;
      end
      if (ackNow) ack_tgl <= xfer_stb;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  task automatic pushGrant(input int idx, input logic [N-1:0] data, input int lat);
    expT e;
    e.kind  = EV_GRANT;
    e.grant = NREQ'(1) << idx;
    e.data  = data;
    e.src   = IW'(idx);
    expStb  = ~expStb;
    e.stb   = expStb;
    e.lat   = lat;
    expQ.push_back(e);
  endtask

  task automatic pushEvent(input int kind, input int lat);
    expT e;
    e.kind  = kind;
    e.grant = '0;
    e.data  = '0;
    e.src   = '0;
    e.stb   = 1'b0;
    e.lat   = lat;
    expQ.push_back(e);
  endtask

  task automatic checkEvent(input int kind);
    expT e;
    bit  ok;
    int  lat;
    lat = cycleCnt - lastGrantCycle;
    compared++;
    if (expQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL unexpected_event: got kind=%0d at cycle %0d, expected no event", kind, cycleCnt);
    end else begin
      e  = expQ.pop_front();
      ok = (e.kind == kind) && (e.lat < 0 || e.lat == lat);
      if (kind == EV_GRANT) begin
        ok = ok && (grant === e.grant) && (xfer_data === e.data) &&
             (src_id === e.src) && (xfer_stb === e.stb);
      end
      if (!ok) begin
        mismatched++;
        $display("[TB] FAIL event_check: got kind=%0d grant=%b data=0x%0h src=%0d stb=%b lat=%0d, expected kind=%0d grant=%b data=0x%0h src=%0d stb=%b lat=%0d",
                 kind, grant, xfer_data, src_id, xfer_stb, lat,
                 e.kind, e.grant, e.data, e.src, e.stb, e.lat);
      end
    end
    if (kind == EV_GRANT) begin
      lastGrantCycle = cycleCnt;
      grantsSeen++;
    end
  endtask

  task automatic monitorLoop();
    forever begin
      @(negedge clkA);
      if (rst_n === 1'b1) begin
        if (grant !== '0)         checkEvent(EV_GRANT);
        if (done === 1'b1)        checkEvent(EV_DONE);
        if (timeout_err === 1'b1) checkEvent(EV_TIMEOUT);
      end
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] reqVec);
    req = reqVec;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_grant"}, 32'(grant), 0);
    checkOutput({tag, "_xfer_data"}, 32'(xfer_data), 0);
    checkOutput({tag, "_xfer_stb"}, 32'(xfer_stb), 0);
    checkOutput({tag, "_src_id"}, 32'(src_id), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 0);
    checkOutput({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic resetDut();
    @(negedge clkA);
    rst_n   = 1'b0;
    req     = '0;
    enaA    = 1'b1;
    err_clr = 1'b0;
    ackAuto = 1'b0;
    ackNow  = 1'b0;
    expStb  = 1'b0;
    @(negedge clkA);
    @(negedge clkA);
    rst_n = 1'b1;
  endtask

  task automatic waitEvents(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (expQ.size() == 0) break;
      @(negedge clkA);
    end
    checkOutput({name, "_events_seen"}, 32'(expQ.size()), 0);
  endtask

  task automatic waitIdle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) break;
      @(negedge clkA);
    end
    checkOutput({name, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    enaA     = 1'b1;
    req      = '0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    err_clr  = 1'b0;
    fork
      monitorLoop();
    join_none

    // Power-on reset state.
    @(negedge clkA);
    checkResetValues("por");

    // Single request with the ack returned 4 edges after launch.
    resetDut();
    req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
    ackDelay = 4;
    ackAuto  = 1'b1;
    pushGrant(0, 8'hA5, -1);
    pushEvent(EV_DONE, 4 + SYNC + 1);
    applyStimulus(4'b0001);
    @(negedge clkA);
    req = '0;
    repeat (9) @(negedge clkA);
    checkOutput("single_busy_in_gap", 32'(busy), 1);
    checkOutput("single_data_stable", 32'(xfer_data), 32'hA5);
    @(negedge clkA);
    checkOutput("single_busy_after_gap", 32'(busy), 0);
    checkOutput("single_stb_level", 32'(xfer_stb), 1);
    waitEvents(5, "single");

    // Round robin with every request held; grant-to-grant spacing 11.
    resetDut();
    req_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    ackDelay   = 4;
    ackAuto    = 1'b1;
    grantsSeen = 0;
    pushGrant(0, 8'h11, -1); pushEvent(EV_DONE, 7);
    pushGrant(1, 8'h22, 11); pushEvent(EV_DONE, 7);
    pushGrant(2, 8'h33, 11); pushEvent(EV_DONE, 7);
    pushGrant(3, 8'h44, 11); pushEvent(EV_DONE, 7);
    pushGrant(0, 8'h11, 11); pushEvent(EV_DONE, 7);
    applyStimulus(4'b1111);
    for (int i = 0; i < 200; i++) begin
      @(negedge clkA);
      if (grantsSeen >= 5) break;
    end
    req = '0;
    checkOutput("rr_five_grants", 32'(grantsSeen >= 5), 1);
    waitEvents(50, "rr");
    waitIdle(20, "rr");

    // Timeout with no ack, err_clr ignored until the late ack arrives.
    resetDut();
    ackAuto = 1'b0;
    pushGrant(1, 8'h22, -1);
    pushEvent(EV_TIMEOUT, TIMEOUT);
    applyStimulus(4'b0010);
    @(negedge clkA);
    req = '0;
    waitEvents(TIMEOUT + 40, "timeout");
    @(negedge clkA);
    checkOutput("to_err_set", 32'(err), 1);
    checkOutput("to_busy", 32'(busy), 1);
    checkOutput("to_pulse_ended", 32'(timeout_err), 0);
    err_clr = 1'b1;
    repeat (3) @(negedge clkA);
    checkOutput("to_err_clr_ignored", 32'(err), 1);
    err_clr = 1'b0;
    ackNow  = 1'b1;
    repeat (4) @(negedge clkA);
    ackNow = 1'b0;
    checkOutput("to_err_held_without_clr", 32'(err), 1);
    err_clr = 1'b1;
    @(negedge clkA);
    err_clr = 1'b0;
    checkOutput("to_err_cleared", 32'(err), 0);
    checkOutput("to_busy_in_gap", 32'(busy), 1);
    ackDelay = 4;
    ackAuto  = 1'b1;
    pushGrant(0, 8'h11, -1);
    pushEvent(EV_DONE, 7);
    applyStimulus(4'b0001);
    repeat (3) @(negedge clkA);
    checkOutput("to_idle_after_gap", 32'(busy), 0);
    checkOutput("to_no_grant_in_gap", 32'(grant), 0);
    @(negedge clkA);
    checkOutput("to_grant_after_gap", 32'(grant), 32'b0001);
    req = '0;
    waitEvents(30, "to_recover");
    waitIdle(20, "to_recover");

    // enaA dropped for 10 edges during WAIT while the ack arrives.
    resetDut();
    ackDelay = 4;
    ackAuto  = 1'b1;
    pushGrant(0, 8'h11, -1);
    pushEvent(EV_DONE, 12);
    applyStimulus(4'b0001);
    @(negedge clkA);
    req = '0;
    @(negedge clkA);
    enaA = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clkA);
      checkOutput("ena_no_done_while_low", 32'(done), 0);
    end
    enaA = 1'b1;
    @(negedge clkA);
    checkOutput("ena_done_on_reenable", 32'(done), 1);
    waitEvents(10, "ena");
    waitIdle(20, "ena");

    // Asynchronous reset in the middle of WAIT, then a clean transfer.
    resetDut();
    ackAuto = 1'b0;
    pushGrant(2, 8'h33, -1);
    applyStimulus(4'b0100);
    @(negedge clkA);
    req = '0;
    repeat (5) @(negedge clkA);
    checkOutput("mid_busy_before_reset", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("mid");
    @(negedge clkA);
    rst_n    = 1'b1;
    expStb   = 1'b0;
    ackDelay = 4;
    ackAuto  = 1'b1;
    pushGrant(0, 8'h11, -1);
    pushEvent(EV_DONE, 7);
    applyStimulus(4'b0001);
    @(negedge clkA);
    req = '0;
    waitEvents(30, "mid_fresh");
    waitIdle(20, "mid_fresh");

    // Ack lands on the last counted WAIT cycle: done wins over timeout.
    resetDut();
    ackDelay = TIMEOUT - SYNC - 1;
    ackAuto  = 1'b1;
    pushGrant(3, 8'h44, -1);
    pushEvent(EV_DONE, TIMEOUT);
    applyStimulus(4'b1000);
    @(negedge clkA);
    req = '0;
    waitEvents(TIMEOUT + 40, "race");
    @(negedge clkA);
    checkOutput("race_no_err", 32'(err), 0);
    checkOutput("race_no_timeout", 32'(timeout_err), 0);
    waitIdle(20, "race");

    repeat (5) @(negedge clkA);
    checkOutput("queue_drained", 32'(expQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
